axi_read_route_ctrl: RTL

AXI_READ_ROUTE_CTRL -- requirements
Module: axi_read_route_ctrl

---
 rtl/axi_read_route_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/axi_read_route_ctrl.sv
// rtl/axi_read_route_ctrl.sv - in-order R-channel router for 4 slaves; optional stall timeout via RD_TIMEOUT_EN
module axi_read_route_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     ar_fire,
  input  logic [1:0]               ar_sel,
  output logic                     ar_allow,
  input  logic [3:0]               s_rvalid,
  input  logic [3:0]               s_rlast,
  input  logic                     m_rready,
  output logic [1:0]               sel,
  output logic                     m_rvalid,
  output logic [3:0]               s_rready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          hs;

  assign empty    = (outstanding == '0);
  assign full     = (outstanding == CNT_FULL);
  assign ar_allow = !full;
  assign push     = ar_fire && !full;

  assign sel      = empty ? 2'b00 : mem[rd_ptr];
  assign m_rvalid = !empty && s_rvalid[sel];
  assign hs       = m_rvalid && m_rready;
  assign pop      = hs && s_rlast[sel];

  always_comb begin
    s_rready = 4'b0000;
    if (!empty && m_rready)
      s_rready = 4'b0001 << sel;
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge ACLK) begin
    if (push)
      mem[wr_ptr] <= ar_sel;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef RD_TIMEOUT_EN
  localparam logic [15:0] TO_ARM = 16'(TIMEOUT - 2);
  localparam logic [15:0] TO_MAX = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt;
  logic        idle;

  assign idle = !empty && !hs;

  // Error latches on the idle cycle that brings the count to TIMEOUT-1.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!idle)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 16'd1;
      if (idle && (to_cnt == TO_ARM))
        timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
